// File: rtl/mux_pipe_pkg.sv
// Shared definitions for the pipelined N:1 operand select: FSM encoding and beat sizing.
package mux_pipe_pkg;

    // Encoding 2'd3 is unused and recovers to EMPTY.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    // A stored beat is {data, sel, err}.
    function automatic int beat_w(input int width, input int sel_w);
        return width + sel_w + 1;
    endfunction

endpackage

// File: rtl/mux_nto1.sv
// Combinational N:1 channel select; an out-of-range select yields zero data with err set.
module mux_nto1 #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int SEL_W = $clog2(N)
) (
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]   in_sel,
    output logic [WIDTH-1:0]   data,
    output logic               err
);

    // err is "no channel matched", so no compare against N is needed.
    always_comb begin
        data = '0;
        err  = 1'b1;
        for (int unsigned k = 0; k < N; k++) begin
            if (in_sel == SEL_W'(k)) begin
                data = in_data[k*WIDTH +: WIDTH];
                err  = 1'b0;
            end
        end
    end

endmodule

// File: rtl/mux_pipe_nto1.sv
// Registered N:1 datapath select with valid/ready handshake and a one-entry skid buffer.
module mux_pipe_nto1 #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int SEL_W = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]   in_sel,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [SEL_W-1:0]   out_sel,
    output logic               out_err,
    output logic               out_valid,
    input  logic               out_ready
);
    import mux_pipe_pkg::*;

    localparam int BW = beat_w(WIDTH, SEL_W);

    if (N < 2) begin : g_bad_n
        $error("mux_pipe_nto1: N must be at least 2");
    end

    state_t            state;
    logic [BW-1:0]     main_q;
    logic [BW-1:0]     skid_q;
    logic [BW-1:0]     new_beat;
    logic [WIDTH-1:0]  mux_data;
    logic              mux_err;
    logic              in_fire;
    logic              out_fire;

    mux_nto1 #(
        .WIDTH (WIDTH),
        .N     (N),
        .SEL_W (SEL_W)
    ) u_mux (
        .in_data (in_data),
        .in_sel  (in_sel),
        .data    (mux_data),
        .err     (mux_err)
    );

    assign new_beat = {mux_data, in_sel, mux_err};

    // Handshake outputs decode the state register only: no comb path from in_valid/out_ready.
    assign in_ready  = (state != SKID);
    assign out_valid = (state != EMPTY);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    assign out_data = main_q[BW-1 -: WIDTH];
    assign out_sel  = main_q[1 +: SEL_W];
    assign out_err  = main_q[0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= EMPTY;
            main_q <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        main_q <= new_beat;
                        state  <= FULL;
                    end
                end
                FULL: begin
                    if (in_fire && out_fire) begin
                        main_q <= new_beat;
                    end else if (in_fire) begin
                        skid_q <= new_beat;
                        state  <= SKID;
                    end else if (out_fire) begin
                        state  <= EMPTY;
                    end
                end
                SKID: begin
                    if (out_fire) begin
                        main_q <= skid_q;
                        state  <= FULL;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_mux_pipe_nto1.sv
// Scoreboard bench for mux_pipe_nto1 across three configurations (N=4/W=32, N=3/W=16, N=5/W=8).
module tb_mux_pipe_nto1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int total = 0;
    int bad   = 0;

    typedef logic [35:0] beat_t;
    beat_t qa[$];
    beat_t qb[$];
    beat_t qc[$];

    // ---------------- instance a: N=4, WIDTH=32
    logic [127:0] a_in_data;
    logic [1:0]   a_in_sel;
    logic         a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_err;
    logic [31:0]  a_out_data;
    logic [1:0]   a_out_sel;

    mux_pipe_nto1 #(.WIDTH(32), .N(4)) u_a (
        .clk(clk), .rst_n(rst_n), .in_data(a_in_data), .in_sel(a_in_sel),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .out_data(a_out_data),
        .out_sel(a_out_sel), .out_err(a_out_err), .out_valid(a_out_valid),
        .out_ready(a_out_ready)
    );

    // ---------------- instance b: N=3, WIDTH=16
    logic [47:0]  b_in_data;
    logic [1:0]   b_in_sel;
    logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_err;
    logic [15:0]  b_out_data;
    logic [1:0]   b_out_sel;

    mux_pipe_nto1 #(.WIDTH(16), .N(3)) u_b (
        .clk(clk), .rst_n(rst_n), .in_data(b_in_data), .in_sel(b_in_sel),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .out_data(b_out_data),
        .out_sel(b_out_sel), .out_err(b_out_err), .out_valid(b_out_valid),
        .out_ready(b_out_ready)
    );

    // ---------------- instance c: N=5, WIDTH=8
    logic [39:0]  c_in_data;
    logic [2:0]   c_in_sel;
    logic         c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_out_err;
    logic [7:0]   c_out_data;
    logic [2:0]   c_out_sel;

    mux_pipe_nto1 #(.WIDTH(8), .N(5)) u_c (
        .clk(clk), .rst_n(rst_n), .in_data(c_in_data), .in_sel(c_in_sel),
        .in_valid(c_in_valid), .in_ready(c_in_ready), .out_data(c_out_data),
        .out_sel(c_out_sel), .out_err(c_out_err), .out_valid(c_out_valid),
        .out_ready(c_out_ready)
    );

    logic [31:0] a_val [4];
    logic [7:0]  c_val [5];

    function automatic beat_t pk(input logic [31:0] d, input logic [2:0] s, input logic e);
        return {d, s, e};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic timeout_fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: got no in_ready within 64 cycles, expected acceptance", name);
    endtask

    task automatic send_a(input logic [1:0] sel, input logic [31:0] d, output int waited);
        a_in_sel = sel; a_in_valid = 1'b1; waited = 0;
        forever begin
            @(negedge clk);
            if (a_in_ready) break;
            waited++;
            if (waited >= 64) break;
        end
        if (waited >= 64) timeout_fail("a_accept");
        @(posedge clk);
        if (waited < 64) qa.push_back(pk(d, {1'b0, sel}, 1'b0));
        #1;
    endtask

    task automatic send_b(input logic [1:0] sel, input logic [15:0] d, input logic e, output int waited);
        b_in_sel = sel; b_in_valid = 1'b1; waited = 0;
        forever begin
            @(negedge clk);
            if (b_in_ready) break;
            waited++;
            if (waited >= 64) break;
        end
        if (waited >= 64) timeout_fail("b_accept");
        @(posedge clk);
        if (waited < 64) qb.push_back(pk({16'h0, d}, {1'b0, sel}, e));
        #1;
    endtask

    task automatic send_c(input logic [2:0] sel, output int waited);
        logic [7:0] d;
        d = (sel < 3'd5) ? c_val[sel] : 8'h00;
        c_in_sel = sel; c_in_valid = 1'b1; waited = 0;
        forever begin
            @(negedge clk);
            if (c_in_ready) break;
            waited++;
            if (waited >= 64) break;
        end
        if (waited >= 64) timeout_fail("c_accept");
        @(posedge clk);
        if (waited < 64) qc.push_back(pk({24'h0, d}, sel, sel >= 3'd5));
        #1;
    endtask

    // Monitors: pop on every out_fire, and require out_* frozen across a stall.
    initial begin
        beat_t cur, prev;
        logic stall;
        stall = 1'b0; prev = '0;
        forever begin
            @(negedge clk);
            cur = pk(a_out_data, {1'b0, a_out_sel}, a_out_err);
            if (rst_n !== 1'b1) stall = 1'b0;
            else begin
                if (stall) check("a_stable", {cur, a_out_valid}, {prev, 1'b1});
                if (a_out_valid && a_out_ready) begin
                    if (qa.size() == 0) begin
                        total++; bad++;
                        $display("FAIL a_unexpected: got beat 0x%0h expected none", cur);
                    end else check("a_beat", cur, qa.pop_front());
                end
                stall = a_out_valid && !a_out_ready;
                prev  = cur;
            end
        end
    end

    initial begin
        beat_t cur, prev;
        logic stall;
        stall = 1'b0; prev = '0;
        forever begin
            @(negedge clk);
            cur = pk({16'h0, b_out_data}, {1'b0, b_out_sel}, b_out_err);
            if (rst_n !== 1'b1) stall = 1'b0;
            else begin
                if (stall) check("b_stable", {cur, b_out_valid}, {prev, 1'b1});
                if (b_out_valid && b_out_ready) begin
                    if (qb.size() == 0) begin
                        total++; bad++;
                        $display("FAIL b_unexpected: got beat 0x%0h expected none", cur);
                    end else check("b_beat", cur, qb.pop_front());
                end
                stall = b_out_valid && !b_out_ready;
                prev  = cur;
            end
        end
    end

    initial begin
        beat_t cur, prev;
        logic stall;
        stall = 1'b0; prev = '0;
        forever begin
            @(negedge clk);
            cur = pk({24'h0, c_out_data}, c_out_sel, c_out_err);
            if (rst_n !== 1'b1) stall = 1'b0;
            else begin
                if (stall) check("c_stable", {cur, c_out_valid}, {prev, 1'b1});
                if (c_out_valid && c_out_ready) begin
                    if (qc.size() == 0) begin
                        total++; bad++;
                        $display("FAIL c_unexpected: got beat 0x%0h expected none", cur);
                    end else check("c_beat", cur, qc.pop_front());
                end
                stall = c_out_valid && !c_out_ready;
                prev  = cur;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion by 1ms, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w;
        bit c_done;
        a_val[0] = 32'h11111111; a_val[1] = 32'h22222222;
        a_val[2] = 32'h33333333; a_val[3] = 32'h44444444;
        c_val[0] = 8'h5A; c_val[1] = 8'hC3; c_val[2] = 8'h0F; c_val[3] = 8'hF0; c_val[4] = 8'h99;
        a_in_data = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        b_in_data = {16'hCCCC, 16'hBBBB, 16'hAAAA};
        c_in_data = {8'h99, 8'hF0, 8'h0F, 8'hC3, 8'h5A};
        a_in_sel = 2'd3; a_in_valid = 1'b1; a_out_ready = 1'b1;
        b_in_sel = 2'd0; b_in_valid = 1'b0; b_out_ready = 1'b1;
        c_in_sel = 3'd0; c_in_valid = 1'b0; c_out_ready = 1'b1;
        c_done = 1'b0;

        // reset; a offers a beat during reset which must be dropped
        rst_n = 1'b0;
        cyc(3);
        a_in_valid = 1'b0;
        check("rst_out_valid", a_out_valid, 1'b0);
        check("rst_out_data",  a_out_data, 32'h0);
        check("rst_out_sel",   a_out_sel, 2'd0);
        check("rst_out_err",   a_out_err, 1'b0);
        check("rst_in_ready",  a_in_ready, 1'b1);
        rst_n = 1'b1;

        // single beat
        send_a(2'd2, 32'h33333333, w);
        check("single_wait", w, 0);
        a_in_valid = 1'b0;
        check("single_valid", a_out_valid, 1'b1);
        check("single_data",  a_out_data, 32'h33333333);
        check("single_sel",   a_out_sel, 2'd2);
        check("single_err",   a_out_err, 1'b0);
        cyc(1);
        check("single_drop", a_out_valid, 1'b0);

        // streaming
        for (int i = 0; i < 8; i++) begin
            send_a(2'(i % 4), a_val[i % 4], w);
            check("stream_ready", w, 0);
        end
        a_in_valid = 1'b0;
        cyc(3);

        // backpressure
        a_out_ready = 1'b0;
        send_a(2'd0, 32'h11111111, w);
        send_a(2'd1, 32'h22222222, w);
        check("bp_second_wait", w, 0);
        a_in_sel = 2'd3; a_in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("bp_ready_low", a_in_ready, 1'b0);
            check("bp_hold", a_out_data, 32'h11111111);
            cyc(1);
        end
        a_out_ready = 1'b1;
        send_a(2'd3, 32'h44444444, w);
        check("bp_resume_wait", w, 1);
        a_in_valid = 1'b0;
        cyc(4);

        // reset while in SKID
        a_out_ready = 1'b0;
        send_a(2'd1, 32'h22222222, w);
        send_a(2'd2, 32'h33333333, w);
        a_in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        qa.delete();
        #1;
        rst_n = 1'b1;
        check("mid_rst_valid", a_out_valid, 1'b0);
        check("mid_rst_data",  a_out_data, 32'h0);
        check("mid_rst_ready", a_in_ready, 1'b1);
        a_out_ready = 1'b1;
        cyc(3);
        send_a(2'd0, 32'h11111111, w);
        check("post_rst_wait", w, 0);
        a_in_valid = 1'b0;
        cyc(3);

        // out of range on N=3
        send_b(2'd3, 16'h0000, 1'b1, w);
        send_b(2'd1, 16'hBBBB, 1'b0, w);
        b_in_valid = 1'b0;
        check("oor_clear_err", b_out_err, 1'b0);
        send_b(2'd0, 16'hAAAA, 1'b0, w);
        send_b(2'd2, 16'hCCCC, 1'b0, w);
        b_in_valid = 1'b0;
        cyc(3);

        // random valid/ready on N=5
        fork
            begin
                while (!c_done) begin
                    c_out_ready = ($urandom_range(0, 3) != 0);
                    @(posedge clk);
                    #1;
                end
                c_out_ready = 1'b1;
            end
            begin
                for (int i = 0; i < 1000; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        c_in_valid = 1'b0;
                        cyc(1);
                    end
                    send_c(3'($urandom_range(0, 7)), w);
                end
                c_in_valid = 1'b0;
                c_done = 1'b1;
            end
        join

        for (int i = 0; i < 200; i++) begin
            if (qa.size() == 0 && qb.size() == 0 && qc.size() == 0) break;
            cyc(1);
        end
        check("drain", qa.size() + qb.size() + qc.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux_pipe_nto1.md
# mux_pipe_nto1

Parametrised N-to-1 datapath selector with a registered output stage and valid/ready flow control. It generalises the fixed 4:1 32-bit combinational operand mux: width and input count are parameters, an out-of-range select is flagged, and a one-entry skid buffer lets it sit between pipeline stages without a combinational ready path. Its first use is the registered operand/forwarding select between ID and EX.

## Interface
- WIDTH, 32, bits per data channel.
- N, 4, number of input channels, minimum 2.
- SEL_W, $clog2(N), select width; derived, not overridden.
- clk  in  1  rising-edge clock, the only clock.
- rst_n  in  1  reset: synchronous, active-low.
- in_data  in  N*WIDTH  flattened channels; channel k is in_data[k*WIDTH +: WIDTH].
- in_sel  in  SEL_W  channel select, sampled with in_data.
- in_valid  in  1  upstream offers in_data/in_sel.
- in_ready  out  1  block accepts this cycle.
- out_data  out  WIDTH  selected channel, registered.
- out_sel  out  SEL_W  select value that produced out_data.
- out_err  out  1  in_sel was >= N; out_data is 0.
- out_valid  out  1  out_* hold a valid beat.
- out_ready  in  1  downstream accepts this cycle.

## Operation
- Transfers: in_fire = in_valid & in_ready. out_fire = out_valid & out_ready.
- Beat value: {data, sel, err}.
  - data = channel in_sel, or 0 when in_sel >= N.
  - err = (in_sel >= N). This is only reachable when N is not a power of two.
- Storage: a main register that drives out_* and a skid register. Each holds one beat.
- States:
  - EMPTY: main is invalid.
  - FULL: main is valid.
  - SKID: main and skid are both valid.
- Outputs by state:
  - out_valid = (state != EMPTY).
  - in_ready = (state != SKID). Both decode the state register only, with no combinational path from in_valid or out_ready.
- Transitions from EMPTY:
  - in_fire: load main, go to FULL.
  - Otherwise stay in EMPTY.
- Transitions from FULL:
  - in_fire & out_fire: load main with the new beat, stay in FULL.
  - in_fire & !out_fire: load skid, go to SKID.
  - !in_fire & out_fire: go to EMPTY.
  - Neither: hold.
- Transitions from SKID:
  - out_fire: main <= skid, go to FULL.
  - Otherwise hold. in_valid is ignored because in_ready = 0.
- Ordering is strictly FIFO. There is no loss and no duplication.
- While out_valid = 1 and out_ready = 0, out_* stay stable until out_fire.
- Contents of main/skid are don't-care when invalid. Even so, main data clears to 0 on reset.

## Timing
- Latency: a beat accepted at edge t is presented on out_* after edge t, i.e. one cycle. A new beat is visible only after the edge that accepts it; no input reaches an output combinationally.
- Throughput: one beat per cycle while out_ready = 1.
- in_ready falls one cycle after the first stalled accept. It rises on the edge after the out_fire that drains skid.
- Reset (rst_n sampled low at an edge) forces state = EMPTY and main = 0:
  - out_valid = 0, out_data = 0, out_sel = 0, out_err = 0, in_ready = 1.
  - Reset mid-operation discards both stored beats with no partial output.
  - An in_fire in the same cycle as reset is dropped.
- In the first cycle after rst_n rises, in_ready = 1 and a beat may be accepted.
- out_ready toggling while out_valid = 0 has no effect.

## Structure
- Package mux_pipe_pkg:
  - State enum: EMPTY = 2'd0, FULL = 2'd1, SKID = 2'd2; 2'd3 is illegal and recovers to EMPTY.
  - Beat struct/width helper: WIDTH + SEL_W + 1.
- Sub-module mux_nto1: purely combinational, parametrised WIDTH/N. It produces {data, err} from in_data/in_sel. It is the only place channel indexing occurs.
- Top level contains the FSM, the main register and the skid register.

## Test plan
- Reset then single beat, WIDTH = 32, N = 4:
  - Stimulus: ch0..3 = 0x11111111/0x22222222/0x33333333/0x44444444, in_sel = 2, out_ready = 1.
  - Required: out_data = 0x33333333, out_sel = 2, out_err = 0, out_valid = 1 one cycle after accept, then 0.
- Streaming: 8 back-to-back beats with in_sel cycling 0,1,2,3 and out_ready = 1 -> 8 outputs in order, in_ready constantly 1, one beat per cycle.
- Backpressure:
  - Stimulus: out_ready = 0 while 3 beats (sel 0, 1, 3) are offered.
  - Required: 2 accepted, in_ready = 0 from the cycle after the second accept, out_data holds the 0x11111111 beat stable.
  - Then out_ready = 1: outputs are 0x11111111, 0x22222222, 0x44444444 in order.
- Out of range, N = 3, WIDTH = 16: in_sel = 3 -> out_data = 0x0000, out_err = 1, out_sel = 3. A following in_sel = 1 beat clears out_err.
- Reset mid-operation: in SKID state, pulse rst_n low for 1 cycle -> next cycle out_valid = 0, out_data = 0, in_ready = 1. The two stored beats never appear.
- Randomised valid/ready toggling for 1000 beats, N = 5, WIDTH = 8 -> output sequence equals a reference queue, and out_* are stable while stalled.
